detector_seq_ctrl: RTL and testbench
====================================

DETECTOR_SEQ_CTRL -- requirements
Module: detector_seq_ctrl

Interface
REQ-001 SHALL have parameters as follows.
- RST_CYC, default 32'd1000: detector reset hold length, in cycles.
- BOOT_CYC, default 32'd100000: detector boot wait after reset release, in cycles.
- WDOG_CYC, default 32'd240000: maximum cycles between frames in RUN.
- MAX_RETRY, default 2'd3: automatic recoveries allowed before ERROR.
- INTERLINE_INIT, default 8'd16: interline reset value.
REQ-002 SHALL have ports as follows.
- clk, in, 1: the single clock.
- rst, in, 1: reset, asynchronous, active-high.
- cmd_start, in, 1: one-cycle pulse; begins power-up.
- cmd_stop, in, 1: one-cycle pulse; returns to IDLE.
- cfg_i2c_addr, in, 1: requested detector I2C address select.
- cfg_interline, in, 8: requested interline blanking.
- cfg_wr, in, 1: one-cycle write strobe for cfg_interline.
- frame_eop, in, 1: end-of-frame strobe from the detector video stream (dout_endofpacket).
- reset_n_reg, out, 1: detector reset, active-low.
- i2c_address_reg, out, 1: detector I2C address pin.
- interline_reg, out, 8: interline value applied to the detector datapath.
- stream_en, out, 1: high only in RUN.
- fault, out, 1: high only in ERROR.
- state_o, out, 3: current state encoding.
- retry_cnt, out, 2: recoveries since the last good frame.
- frame_cnt, out, 16: frames received in RUN.

Function
REQ-003 SHALL implement states IDLE=0, RST_HOLD=1, BOOT=2, RUN=3, RECOVER=4, ERROR=5; state_o SHALL equal the registered state, and unused encodings SHALL go to IDLE.
REQ-004 SHALL use one 32-bit phase counter, cleared on every state change and incremented every cycle otherwise.
REQ-005 cmd_stop SHALL move any state to IDLE on the next cycle and SHALL take priority over all other events.
REQ-006 IDLE: on cmd_start, go to RST_HOLD; clear retry_cnt and frame_cnt; latch cfg_i2c_addr into i2c_address_reg.
REQ-007 RST_HOLD: reset_n_reg=0; remain exactly RST_CYC cycles, then go to BOOT.
REQ-008 BOOT: reset_n_reg=1; remain exactly BOOT_CYC cycles, then go to RUN.
REQ-009 RUN: reset_n_reg=1 and stream_en=1; frame_eop clears the phase counter, increments frame_cnt (wrapping 16'hFFFF->0) and clears retry_cnt.
REQ-010 RUN watchdog: when the counter reaches WDOG_CYC-1 with no frame_eop, go to RECOVER if retry_cnt<MAX_RETRY, otherwise go to ERROR.
REQ-011 If frame_eop and watchdog expiry occur in the same cycle, frame_eop SHALL win and the state SHALL stay RUN.
REQ-012 RECOVER: lasts one cycle with reset_n_reg=0; retry_cnt increments; then go to RST_HOLD; i2c_address_reg is held.
REQ-013 ERROR: reset_n_reg=0 and fault=1; only cmd_stop exits.
REQ-014 reset_n_reg SHALL be 0 in IDLE, RST_HOLD, RECOVER and ERROR.
REQ-015 On cfg_wr, cfg_interline SHALL be stored in a shadow register.
REQ-016 Outside RUN, the shadow value SHALL reach interline_reg one cycle after cfg_wr.
REQ-017 In RUN, interline_reg SHALL update only on the cycle after frame_eop; if cfg_wr and frame_eop coincide, the newly written value SHALL be applied.
REQ-018 cmd_start outside IDLE SHALL be ignored.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 On rst: state=IDLE; reset_n_reg=0; i2c_address_reg=0; interline_reg and shadow=INTERLINE_INIT; stream_en=0; fault=0; retry_cnt=0; frame_cnt=0; phase counter=0.
REQ-021 rst asserted mid-sequence SHALL abort immediately to the reset values, and nothing SHALL resume after rst is released.

Verification (RST_CYC=4, BOOT_CYC=8, WDOG_CYC=20, MAX_RETRY=2)
REQ-022 Power-up: cmd_start with cfg_i2c_addr=1 -> reset_n_reg low for 4 cycles after IDLE exit, high for 8 cycles in BOOT, then stream_en=1; i2c_address_reg=1 throughout.
REQ-023 Watchdog: no frame_eop in RUN -> RECOVER after 20 cycles; after 2 recoveries, the third expiry gives ERROR with fault=1 and retry_cnt=2; cmd_stop -> IDLE.
REQ-024 Race: frame_eop on the same cycle as watchdog expiry -> stays RUN, frame_cnt+1, retry_cnt=0.
REQ-025 Interline: cfg_wr 8'd40 mid-frame -> interline_reg stays 16 until the cycle after frame_eop, then becomes 40; cfg_wr in IDLE -> applied the next cycle.
REQ-026 Stop/reset: cmd_stop during BOOT -> IDLE next cycle with reset_n_reg=0; rst during RUN -> all outputs at reset values while rst is high.
REQ-027 Wrap: 65536 frame_eop pulses in RUN -> frame_cnt returns to 0.

Source files
------------

// File: rtl/detector_seq_ctrl.sv
// -----------------------------------------------------------------------------
// detector_seq_ctrl
// Power-up / recovery sequencer for an image detector. Drives the detector
// reset pin and I2C address select, waits out its boot time, enables the
// video stream and supervises it with a frame watchdog. A stalled stream
// triggers a bounded number of automatic reset/boot retries before latching
// a fault. The interline blanking value is double-buffered so that a change
// requested while streaming only lands on a frame boundary.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module detector_seq_ctrl #(
  parameter logic [31:0] RST_CYC        = 32'd1000,
  parameter logic [31:0] BOOT_CYC       = 32'd100000,
  parameter logic [31:0] WDOG_CYC       = 32'd240000,
  parameter logic [1:0]  MAX_RETRY      = 2'd3,
  parameter logic [7:0]  INTERLINE_INIT = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cfg_i2c_addr,
  input  logic [7:0]  cfg_interline,
  input  logic        cfg_wr,
  input  logic        frame_eop,
  output logic        reset_n_reg,
  output logic        i2c_address_reg,
  output logic [7:0]  interline_reg,
  output logic        stream_en,
  output logic        fault,
  output logic [2:0]  state_o,
  output logic [1:0]  retry_cnt,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_BOOT     = 3'd2,
    ST_RUN      = 3'd3,
    ST_RECOVER  = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] phase_cnt_r;
  logic [31:0] phase_cnt_next_s;
  logic [7:0]  shadow_r;
  logic [7:0]  shadow_next_s;
  logic [7:0]  interline_next_s;
  logic [1:0]  retry_next_s;
  logic [15:0] frame_next_s;
  logic        i2c_next_s;
  logic        rstn_next_s;
  logic        stream_next_s;
  logic        fault_next_s;

  // Qualified events: cmd_stop overrides everything else in the same cycle.
  logic start_acc_s;
  logic frame_acc_s;
  logic recover_s;
  logic rst_hold_done_s;
  logic boot_done_s;
  logic wdog_expired_s;

  assign start_acc_s     = !cmd_stop && (state_r == ST_IDLE) && cmd_start;
  assign frame_acc_s     = !cmd_stop && (state_r == ST_RUN) && frame_eop;
  assign recover_s       = !cmd_stop && (state_r == ST_RECOVER);
  assign rst_hold_done_s = (phase_cnt_r == (RST_CYC - 32'd1));
  assign boot_done_s     = (phase_cnt_r == (BOOT_CYC - 32'd1));
  assign wdog_expired_s  = (phase_cnt_r == (WDOG_CYC - 32'd1));

  assign state_o = state_r;

  // Next-state decision for the sequencer.
  always_comb begin
    state_next_s = state_r;
    if (cmd_stop) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_start) begin
            state_next_s = ST_RST_HOLD;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_RST_HOLD: begin
          if (rst_hold_done_s) begin
            state_next_s = ST_BOOT;
          end else begin
            state_next_s = ST_RST_HOLD;
          end
        end
        ST_BOOT: begin
          if (boot_done_s) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_BOOT;
          end
        end
        ST_RUN: begin
          // A frame arriving on the expiry cycle still counts as alive.
          if (frame_eop) begin
            state_next_s = ST_RUN;
          end else if (wdog_expired_s) begin
            if (retry_cnt < MAX_RETRY) begin
              state_next_s = ST_RECOVER;
            end else begin
              state_next_s = ST_ERROR;
            end
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_RECOVER: begin
          state_next_s = ST_RST_HOLD;
        end
        ST_ERROR: begin
          state_next_s = ST_ERROR;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Phase counter restarts on every state change and on each accepted frame.
  always_comb begin
    phase_cnt_next_s = phase_cnt_r + 32'd1;
    if (state_next_s != state_r) begin
      phase_cnt_next_s = 32'd0;
    end else if (frame_acc_s) begin
      phase_cnt_next_s = 32'd0;
    end else begin
      phase_cnt_next_s = phase_cnt_r + 32'd1;
    end
  end

  // Session bookkeeping: retry/frame counters and the latched I2C address.
  always_comb begin
    retry_next_s = retry_cnt;
    frame_next_s = frame_cnt;
    i2c_next_s   = i2c_address_reg;
    if (start_acc_s) begin
      retry_next_s = 2'd0;
      frame_next_s = 16'd0;
      i2c_next_s   = cfg_i2c_addr;
    end else if (frame_acc_s) begin
      retry_next_s = 2'd0;
      frame_next_s = frame_cnt + 16'd1;
      i2c_next_s   = i2c_address_reg;
    end else if (recover_s) begin
      retry_next_s = retry_cnt + 2'd1;
      frame_next_s = frame_cnt;
      i2c_next_s   = i2c_address_reg;
    end else begin
      retry_next_s = retry_cnt;
      frame_next_s = frame_cnt;
      i2c_next_s   = i2c_address_reg;
    end
  end

  // Pin-level controls decoded from the state being entered, so they line up with state_o.
  always_comb begin
    rstn_next_s   = 1'b0;
    stream_next_s = 1'b0;
    fault_next_s  = 1'b0;
    case (state_next_s)
      ST_BOOT: begin
        rstn_next_s   = 1'b1;
        stream_next_s = 1'b0;
        fault_next_s  = 1'b0;
      end
      ST_RUN: begin
        rstn_next_s   = 1'b1;
        stream_next_s = 1'b1;
        fault_next_s  = 1'b0;
      end
      ST_ERROR: begin
        rstn_next_s   = 1'b0;
        stream_next_s = 1'b0;
        fault_next_s  = 1'b1;
      end
      default: begin
        rstn_next_s   = 1'b0;
        stream_next_s = 1'b0;
        fault_next_s  = 1'b0;
      end
    endcase
  end

  // Interline double buffer: while streaming, only a frame boundary applies the
  // shadow; a write coinciding with that boundary is taken directly.
  always_comb begin
    if (cfg_wr) begin
      shadow_next_s = cfg_interline;
    end else begin
      shadow_next_s = shadow_r;
    end
    if (state_r == ST_RUN) begin
      if (frame_eop) begin
        interline_next_s = shadow_next_s;
      end else begin
        interline_next_s = interline_reg;
      end
    end else begin
      interline_next_s = shadow_next_s;
    end
  end

  // State register and phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      phase_cnt_r <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      phase_cnt_r <= phase_cnt_next_s;
    end
  end

  // Registered status and detector control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reset_n_reg     <= 1'b0;
      stream_en       <= 1'b0;
      fault           <= 1'b0;
      retry_cnt       <= 2'd0;
      frame_cnt       <= 16'd0;
      i2c_address_reg <= 1'b0;
    end else begin
      reset_n_reg     <= rstn_next_s;
      stream_en       <= stream_next_s;
      fault           <= fault_next_s;
      retry_cnt       <= retry_next_s;
      frame_cnt       <= frame_next_s;
      i2c_address_reg <= i2c_next_s;
    end
  end

  // Interline shadow and applied value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r      <= INTERLINE_INIT;
      interline_reg <= INTERLINE_INIT;
    end else begin
      shadow_r      <= shadow_next_s;
      interline_reg <= interline_next_s;
    end
  end

endmodule

// File: tb/tb_detector_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_detector_seq_ctrl
// Directed scenarios plus a randomized soak, all checked every cycle against
// a behavioural model of the sequencer kept in this bench.
// -----------------------------------------------------------------------------
module tb_detector_seq_ctrl;

  localparam int RST_C   = 4;
  localparam int BOOT_C  = 8;
  localparam int WDOG_C  = 20;
  localparam int MAXR    = 2;
  localparam int IL_INIT = 16;

  localparam int S_IDLE = 0;
  localparam int S_RST  = 1;
  localparam int S_BOOT = 2;
  localparam int S_RUN  = 3;
  localparam int S_REC  = 4;
  localparam int S_ERR  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_stop = 1'b0;
  logic        cfg_i2c_addr = 1'b0;
  logic [7:0]  cfg_interline = 8'd0;
  logic        cfg_wr = 1'b0;
  logic        frame_eop = 1'b0;
  logic        reset_n_reg;
  logic        i2c_address_reg;
  logic [7:0]  interline_reg;
  logic        stream_en;
  logic        fault;
  logic [2:0]  state_o;
  logic [1:0]  retry_cnt;
  logic [15:0] frame_cnt;

  detector_seq_ctrl #(
    .RST_CYC(32'd4),
    .BOOT_CYC(32'd8),
    .WDOG_CYC(32'd20),
    .MAX_RETRY(2'd2),
    .INTERLINE_INIT(8'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_start(cmd_start),
    .cmd_stop(cmd_stop),
    .cfg_i2c_addr(cfg_i2c_addr),
    .cfg_interline(cfg_interline),
    .cfg_wr(cfg_wr),
    .frame_eop(frame_eop),
    .reset_n_reg(reset_n_reg),
    .i2c_address_reg(i2c_address_reg),
    .interline_reg(interline_reg),
    .stream_en(stream_en),
    .fault(fault),
    .state_o(state_o),
    .retry_cnt(retry_cnt),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail = 0;
  string cur_phase = "init";

  // Behavioural model: mode, cycles spent in the mode / since last frame.
  int m_state;
  int m_age;
  int m_retry;
  int m_frames;
  int m_i2c;
  int m_shadow;
  int m_interline;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state     = S_IDLE;
    m_age       = 0;
    m_retry     = 0;
    m_frames    = 0;
    m_i2c       = 0;
    m_shadow    = IL_INIT;
    m_interline = IL_INIT;
  endtask

  task automatic model_step(input logic st, input logic sp, input logic ad,
                            input logic wr, input logic [7:0] il, input logic eop);
    int prev;
    int nshadow;
    prev    = m_state;
    nshadow = wr ? int'(il) : m_shadow;
    if (prev != S_RUN || eop) m_interline = nshadow;
    m_shadow = nshadow;
    if (sp) begin
      m_state = S_IDLE;
      m_age   = 0;
    end else begin
      case (prev)
        S_IDLE: if (st) begin
          m_state  = S_RST;
          m_age    = 0;
          m_retry  = 0;
          m_frames = 0;
          m_i2c    = int'(ad);
        end
        S_RST: begin
          m_age++;
          if (m_age == RST_C) begin m_state = S_BOOT; m_age = 0; end
        end
        S_BOOT: begin
          m_age++;
          if (m_age == BOOT_C) begin m_state = S_RUN; m_age = 0; end
        end
        S_RUN: begin
          if (eop) begin
            m_frames = (m_frames + 1) % 65536;
            m_retry  = 0;
            m_age    = 0;
          end else begin
            m_age++;
            if (m_age == WDOG_C) begin
              m_state = (m_retry < MAXR) ? S_REC : S_ERR;
              m_age   = 0;
            end
          end
        end
        S_REC: begin
          m_retry++;
          m_state = S_RST;
          m_age   = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    check_eq({cur_phase, ".state"},     32'(state_o),         32'(m_state));
    check_eq({cur_phase, ".reset_n"},   32'(reset_n_reg),     (m_state == S_BOOT || m_state == S_RUN) ? 32'd1 : 32'd0);
    check_eq({cur_phase, ".stream_en"}, 32'(stream_en),       (m_state == S_RUN) ? 32'd1 : 32'd0);
    check_eq({cur_phase, ".fault"},     32'(fault),           (m_state == S_ERR) ? 32'd1 : 32'd0);
    check_eq({cur_phase, ".retry"},     32'(retry_cnt),       32'(m_retry));
    check_eq({cur_phase, ".frames"},    32'(frame_cnt),       32'(m_frames));
    check_eq({cur_phase, ".i2c"},       32'(i2c_address_reg), 32'(m_i2c));
    check_eq({cur_phase, ".interline"}, 32'(interline_reg),   32'(m_interline));
  endtask

  task automatic cycle(input logic st, input logic sp, input logic ad,
                       input logic wr, input logic [7:0] il, input logic eop);
    @(negedge clk);
    cmd_start     = st;
    cmd_stop      = sp;
    cfg_i2c_addr  = ad;
    cfg_wr        = wr;
    cfg_interline = il;
    frame_eop     = eop;
    @(posedge clk);
    model_step(st, sp, ad, wr, il, eop);
    #1;
    check_all();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic apply_reset();
    @(negedge clk);
    cmd_start = 1'b0; cmd_stop = 1'b0; cfg_wr = 1'b0; frame_eop = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_state(input int s, input int limit);
    int n;
    n = 0;
    while (int'(state_o) != s && n < limit) begin
      idle_cycle();
      n++;
    end
    check_eq({cur_phase, ".reach"}, 32'(state_o), 32'(s));
  endtask

  initial begin
    int n;
    logic st, sp, ad, wr, eop;
    logic [7:0] il;
    int eop_div;

    // Reset values
    cur_phase = "reset";
    apply_reset();

    // Power-up sequence timing
    cur_phase = "pwr";
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    n = 0;
    while (reset_n_reg == 1'b0 && n < 50) begin n++; idle_cycle(); end
    check_eq("pwr.rst_low_cycles", 32'(n), 32'd4);
    n = 0;
    while (reset_n_reg == 1'b1 && stream_en == 1'b0 && n < 50) begin n++; idle_cycle(); end
    check_eq("pwr.boot_cycles", 32'(n), 32'd8);
    check_eq("pwr.stream_en", 32'(stream_en), 32'd1);
    check_eq("pwr.i2c", 32'(i2c_address_reg), 32'd1);

    // Watchdog: two recoveries, then ERROR
    cur_phase = "wdog";
    n = 0;
    while (int'(state_o) == S_RUN && n < 100) begin n++; idle_cycle(); end
    check_eq("wdog.run_cycles", 32'(n), 32'd20);
    check_eq("wdog.recover", 32'(state_o), 32'(S_REC));
    wait_state(S_ERR, 200);
    check_eq("wdog.fault", 32'(fault), 32'd1);
    check_eq("wdog.retry", 32'(retry_cnt), 32'd2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    check_eq("wdog.stop_idle", 32'(state_o), 32'(S_IDLE));

    // Race: frame on the watchdog expiry cycle
    cur_phase = "race";
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    wait_state(S_REC, 100);
    wait_state(S_RUN, 100);
    n = 0;
    while (!(m_state == S_RUN && m_age == WDOG_C - 1) && n < 100) begin n++; idle_cycle(); end
    check_eq("race.retry_before", 32'(retry_cnt), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check_eq("race.state", 32'(state_o), 32'(S_RUN));
    check_eq("race.frames", 32'(frame_cnt), 32'd1);
    check_eq("race.retry", 32'(retry_cnt), 32'd0);

    // Interline shadowing in RUN and in IDLE
    cur_phase = "il";
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd40, 1'b0);
    check_eq("il.hold_wr", 32'(interline_reg), 32'd16);
    for (int i = 0; i < 4; i++) idle_cycle();
    check_eq("il.hold_mid", 32'(interline_reg), 32'd16);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check_eq("il.apply_eop", 32'(interline_reg), 32'd40);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd77, 1'b1);
    check_eq("il.same_cycle", 32'(interline_reg), 32'd77);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd99, 1'b0);
    check_eq("il.idle_apply", 32'(interline_reg), 32'd99);

    // cmd_stop during BOOT
    cur_phase = "stopboot";
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    wait_state(S_BOOT, 20);
    for (int i = 0; i < 3; i++) idle_cycle();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    check_eq("stopboot.state", 32'(state_o), 32'(S_IDLE));
    check_eq("stopboot.rstn", 32'(reset_n_reg), 32'd0);

    // Asynchronous reset during RUN; nothing resumes afterwards
    cur_phase = "rstrun";
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'd55, 1'b0);
    wait_state(S_RUN, 30);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    apply_reset();
    for (int i = 0; i < 6; i++) idle_cycle();
    check_eq("rstrun.idle", 32'(state_o), 32'(S_IDLE));

    // Randomized soak with varying frame rates
    cur_phase = "rand";
    for (int blk = 0; blk < 10; blk++) begin
      eop_div = (blk % 3 == 0) ? 40 : ((blk % 3 == 1) ? 12 : 4);
      for (int i = 0; i < 300; i++) begin
        st  = ($urandom_range(0, 19) == 0);
        sp  = ($urandom_range(0, 299) == 0);
        ad  = ($urandom_range(0, 1) == 1);
        wr  = ($urandom_range(0, 9) == 0);
        il  = 8'($urandom_range(0, 255));
        eop = ($urandom_range(0, eop_div - 1) == 0);
        cycle(st, sp, ad, wr, il, eop);
      end
    end

    // Frame counter wrap
    cur_phase = "wrap";
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    wait_state(S_RUN, 30);
    for (int i = 0; i < 65536; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check_eq("wrap.frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("wrap.state", 32'(state_o), 32'(S_RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
